// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: gray/binary conversion and depth derivation,
// used by the write-side full block, the read-side empty block and gray_counter.
package fifo_pkg;

   localparam int MAX_W = 32;

   function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
      logic [MAX_W-1:0] b;
      b[MAX_W-1] = g[MAX_W-1];
      for (int i = MAX_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Pointers carry one extra wrap bit, so the FIFO holds half the pointer range.
   function automatic int depth_of(input int size);
      return 1 << (size - 1);
   endfunction

endpackage

// File: rtl/sync_ff.sv
// Generic multi-flop synchroniser for gray-coded buses crossing into clk.
// Pure flop chain, nothing between stages.
module sync_ff #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [STAGES-1:0][WIDTH-1:0] chain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/wptr_full_sync.sv
// Write-domain full/level controller: syncs the remote read pointer and
// registers full, almost_full, fill level and an overflow pulse.
module wptr_full_sync
   import fifo_pkg::*;
#(
   parameter int size        = 8,
   parameter int AF_MARGIN   = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            inc,
   input  logic [size-1:0] ptr,
   input  logic [size-1:0] rptr,
   output logic            status,
   output logic            almost_full,
   output logic [size-1:0] level,
   output logic [size-1:0] rptr_sync,
   output logic            overflow
);

   localparam int            DEPTH   = depth_of(size);
   localparam logic [size-1:0] DEPTH_V = size'(DEPTH);
   localparam logic [size-1:0] AF_V    = size'(DEPTH - AF_MARGIN);

   logic [size-1:0] wbin;
   logic [size-1:0] rbin;
   logic [size-1:0] wbin_next;
   logic [size-1:0] lvl_next;
   logic            accept;

   sync_ff #(
      .WIDTH (size),
      .STAGES(SYNC_STAGES)
   ) u_rptr_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (rptr),
      .q    (rptr_sync)
   );

   // wbin_next tracks the gray_counter's own next value, so full rises on the
   // same edge the filling write lands and no extra write slips through.
   assign accept    = inc & ~status;
   assign wbin      = size'(gray2bin({{(MAX_W-size){1'b0}}, ptr}));
   assign rbin      = size'(gray2bin({{(MAX_W-size){1'b0}}, rptr_sync}));
   assign wbin_next = wbin + {{(size-1){1'b0}}, accept};
   assign lvl_next  = wbin_next - rbin;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         status      <= 1'b0;
         almost_full <= 1'b0;
         level       <= '0;
         overflow    <= 1'b0;
      end else begin
         status      <= (lvl_next == DEPTH_V);
         almost_full <= (lvl_next >= AF_V);
         level       <= lvl_next;
         overflow    <= inc & status;
      end
   end

endmodule

// File: tb/tb_wptr_full_sync.sv
// Self-checking bench for wptr_full_sync (size=4, DEPTH=8, AF_MARGIN=2),
// with a behavioural gray_counter producing ptr from inc and status.
module tb_wptr_full_sync;

   localparam int SIZE = 4;

   logic            clk;
   logic            rst_n;
   logic            inc;
   logic [SIZE-1:0] ptr;
   logic [SIZE-1:0] rptr;
   logic            status;
   logic            almost_full;
   logic [SIZE-1:0] level;
   logic [SIZE-1:0] rptr_sync;
   logic            overflow;

   logic [SIZE-1:0] cnt_bin;
   logic [SIZE-1:0] cnt_bnext;

   int checks;
   int failures;

   typedef struct {
      logic            inc;
      logic [SIZE-1:0] rptr;
      logic            exp_status;
      logic            exp_af;
      logic [SIZE-1:0] exp_level;
      logic [SIZE-1:0] exp_ptr;
      logic [SIZE-1:0] exp_rsync;
      logic            exp_ovf;
   } vec_t;

   vec_t vecs[$];

   wptr_full_sync #(
      .size       (SIZE),
      .AF_MARGIN  (2),
      .SYNC_STAGES(2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .inc        (inc),
      .ptr        (ptr),
      .rptr       (rptr),
      .status     (status),
      .almost_full(almost_full),
      .level      (level),
      .rptr_sync  (rptr_sync),
      .overflow   (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [SIZE-1:0] g4(input logic [SIZE-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [SIZE-1:0] b4(input logic [SIZE-1:0] g);
      logic [SIZE-1:0] b;
      b[SIZE-1] = g[SIZE-1];
      for (int i = SIZE - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   // Stand-in for the write-side gray_counter: registered gray of bnext.
   assign cnt_bnext = cnt_bin + {{(SIZE-1){1'b0}}, inc & ~status};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_bin <= '0;
         ptr     <= '0;
      end else begin
         cnt_bin <= cnt_bnext;
         ptr     <= g4(cnt_bnext);
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic i_inc, input logic [SIZE-1:0] i_rptr);
      @(negedge clk);
      inc  = i_inc;
      rptr = i_rptr;
      @(posedge clk);
      #1;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " status"}, 32'(status), 0);
      checkOutput({tag, " almost_full"}, 32'(almost_full), 0);
      checkOutput({tag, " level"}, 32'(level), 0);
      checkOutput({tag, " overflow"}, 32'(overflow), 0);
      checkOutput({tag, " rptr_sync"}, 32'(rptr_sync), 0);
   endtask

   function automatic vec_t mk(input logic i, input logic [SIZE-1:0] r, input logic st,
                               input logic af, input logic [SIZE-1:0] lv,
                               input logic [SIZE-1:0] p, input logic [SIZE-1:0] rs,
                               input logic ov);
      vec_t v;
      v.inc = i; v.rptr = r; v.exp_status = st; v.exp_af = af;
      v.exp_level = lv; v.exp_ptr = p; v.exp_rsync = rs; v.exp_ovf = ov;
      return v;
   endfunction

   initial begin
      logic [SIZE-1:0] fill_ptr [8];
      logic [SIZE-1:0] wb, rb, s1, s2, wbn, lvl;
      logic            st_m, acc, exp_ovf, drive_inc;
      bit              saw_full;

      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      inc      = 1'b0;
      rptr     = '0;

      fill_ptr = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100};

      // Fill from empty, overflow at full, then drain one entry via a remote read.
      for (int k = 1; k <= 8; k++)
         vecs.push_back(mk(1'b1, 4'b0000, k == 8, k >= 6, 4'(k), fill_ptr[k-1], 4'b0000, 1'b0));
      for (int k = 0; k < 3; k++)
         vecs.push_back(mk(1'b1, 4'b0000, 1'b1, 1'b1, 4'd8, 4'b1100, 4'b0000, 1'b1));
      vecs.push_back(mk(1'b0, 4'b0000, 1'b1, 1'b1, 4'd8, 4'b1100, 4'b0000, 1'b0));
      vecs.push_back(mk(1'b0, 4'b0001, 1'b1, 1'b1, 4'd8, 4'b1100, 4'b0000, 1'b0));
      vecs.push_back(mk(1'b0, 4'b0001, 1'b1, 1'b1, 4'd8, 4'b1100, 4'b0001, 1'b0));
      vecs.push_back(mk(1'b0, 4'b0001, 1'b0, 1'b1, 4'd7, 4'b1100, 4'b0001, 1'b0));
      vecs.push_back(mk(1'b1, 4'b0001, 1'b1, 1'b1, 4'd8, 4'b1101, 4'b0001, 1'b0));

      // Reset held with random inputs toggling.
      for (int c = 0; c < 4; c++) begin
         applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
         checkAllZero("reset");
      end
      @(negedge clk);
      inc   = 1'b0;
      rptr  = '0;
      rst_n = 1'b1;

      foreach (vecs[n]) begin
         applyStimulus(vecs[n].inc, vecs[n].rptr);
         checkOutput($sformatf("vec%0d status", n), 32'(status), 32'(vecs[n].exp_status));
         checkOutput($sformatf("vec%0d almost_full", n), 32'(almost_full), 32'(vecs[n].exp_af));
         checkOutput($sformatf("vec%0d level", n), 32'(level), 32'(vecs[n].exp_level));
         checkOutput($sformatf("vec%0d ptr", n), 32'(ptr), 32'(vecs[n].exp_ptr));
         checkOutput($sformatf("vec%0d rptr_sync", n), 32'(rptr_sync), 32'(vecs[n].exp_rsync));
         checkOutput($sformatf("vec%0d overflow", n), 32'(overflow), 32'(vecs[n].exp_ovf));
      end

      // Wrap: 40 cycles with the remote pointer trailing; model carries 2-stage sync lag.
      wb = 4'd9; rb = 4'd1; s1 = g4(4'd1); s2 = g4(4'd1); st_m = 1'b1;
      saw_full = 1'b0;
      for (int i = 0; i < 40; i++) begin
         drive_inc = (i % 10) != 9;
         if (((i % 14) >= 7) && (wb != rb)) rb = rb + 4'd1;
         acc     = drive_inc & ~st_m;
         wbn     = wb + {3'b000, acc};
         lvl     = wbn - b4(s2);
         exp_ovf = drive_inc & st_m;
         applyStimulus(drive_inc, g4(rb));
         checkOutput($sformatf("wrap%0d level", i), 32'(level), 32'(lvl));
         checkOutput($sformatf("wrap%0d status", i), 32'(status), 32'(lvl == 4'd8));
         checkOutput($sformatf("wrap%0d almost_full", i), 32'(almost_full), 32'(lvl >= 4'd6));
         checkOutput($sformatf("wrap%0d overflow", i), 32'(overflow), 32'(exp_ovf));
         checkOutput($sformatf("wrap%0d level_legal", i), 32'(level <= 4'd8), 1);
         if (lvl == 4'd8) saw_full = 1'b1;
         wb   = wbn;
         st_m = (lvl == 4'd8);
         s2   = s1;
         s1   = g4(rb);
      end
      checkOutput("wrap reached_full", 32'(saw_full), 1);

      // Async reset between edges must clear outputs before the next clock edge.
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      inc   = 1'b0;
      rptr  = '0;
      #1;
      checkAllZero("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         applyStimulus(1'b1, 4'b0000);
         checkOutput($sformatf("refill%0d level", k), 32'(level), 32'(k));
         checkOutput($sformatf("refill%0d status", k), 32'(status), 32'(k == 8));
         checkOutput($sformatf("refill%0d almost_full", k), 32'(almost_full), 32'(k >= 6));
         checkOutput($sformatf("refill%0d ptr", k), 32'(ptr), 32'(fill_ptr[k-1]));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
